imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory's write port (`wr`/`addr`/`wdata`).
- Receives a byte-stream program image over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive word addresses, then verifies a trailing XOR checksum.
- Holds the core in reset until a good image is loaded. Sits between the boot/debug byte source and the instruction memory, replacing testbench-driven fills.

Parameters:
WIDTH1, 32, instruction word and address width
MEM_SIZE, 1024, instruction memory depth in words; upper bound on header word count

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
in_valid  input  1  byte source has a byte on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle
start  input  1  single-cycle pulse; re-arms the loader from DONE or ERR
wr  output  1  instruction memory write strobe
addr  output  WIDTH1  instruction memory word index
wdata  output  WIDTH1  instruction word to write
core_hold  output  1  holds the core/PC in reset while high
done  output  1  image loaded and checksum good (level)
error  output  1  bad header or checksum mismatch (level)
words_loaded  output  16  count of words written in the current frame

Behaviour:
- Reset (reset=0, async): state=HDR0; wr=0, addr=0, wdata=0, done=0, error=0, core_hold=1, words_loaded=0, byte index=0, checksum accumulator=0.
- Byte transfer: a byte is accepted on a rising clk edge with in_valid=1 and in_ready=1. in_ready is decoded from state: 1 in HDR0, HDR1, DATA, CHK; 0 in WRITE, DONE, ERR. The source must hold in_data stable while in_valid=1 and in_ready=0. The source must not drive in_valid during reset.
- Frame format: N_lo, N_hi (16-bit word count N), then 4*N payload bytes (byte k of a word goes to bits [8k+7:8k]), then 1 checksum byte equal to the XOR of all payload bytes.
- States:
  - HDR0: accept N_lo -> HDR1.
  - HDR1: accept N_hi. If N==0 or N>MEM_SIZE -> ERR, with no writes. Otherwise -> DATA.
  - DATA: accept bytes into the word shift register and XOR each into the checksum. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle. wr=1, addr=words_loaded (before increment), wdata=assembled word; words_loaded increments at the end of the cycle. Then -> CHK if words_loaded==N after the increment, else -> DATA.
  - CHK: accept the checksum byte. Match -> DONE; mismatch -> ERR.
  - DONE: done=1, core_hold=0.
  - ERR: error=1, core_hold=1.
- Output timing:
  - wr, addr and wdata are registered and change on the same edge.
  - addr and wdata hold their values after wr falls, until the next write.
  - Latency: 4th byte accepted at edge T -> wr=1 during the cycle after T. Minimum 5 cycles per word.
  - Writes already performed are not undone on a checksum error.
- start:
  - Honoured only in DONE or ERR. Next edge -> HDR0 with done=0, error=0, core_hold=1, words_loaded=0, checksum=0. addr/wdata keep their old values.
  - Ignored in every other state.
- Simultaneous events: in_valid during WRITE/DONE/ERR is not accepted (in_ready=0). Asynchronous reset overrides everything, including mid-frame and mid-WRITE (wr drops immediately).

Test Plan:
1. Good image: bytes 02 00 93 00 10 00 13 01 20 00 B1 -> wr pulses with addr=0, wdata=0x00100093, then addr=1, wdata=0x00200113; done=1, core_hold=0, error=0, words_loaded=2.
2. Same frame with checksum byte B0 -> both writes still occur; error=1, done=0, core_hold=1.
3. Bad header: 00 00 -> error=1 after HDR1, no wr. Re-arm with start, then send 01 04 (N=1025) -> error=1, no wr.
4. Back-pressure: in_valid toggling randomly, with the source holding bytes while in_ready=0 (WRITE cycles) -> identical writes and checksum to scenario 1; no byte lost or duplicated.
5. Reset pulse after 5 accepted bytes of the scenario 1 frame -> all outputs at reset values asynchronously. Resend the full frame -> scenario 1 result.
6. start pulse in DATA is ignored. After DONE, start then 01 00 EF BE AD DE 22 -> wr with addr=0, wdata=0xDEADBEEF; done=1, words_loaded=1; core_hold high from start until DONE.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: turns a little-endian byte stream into instruction-memory word writes,
// verifies the trailing XOR checksum, and holds the core in reset until the image is good.
`timescale 1ns/1ps
module imem_loader #(
    parameter int WIDTH1   = 32,
    parameter int MEM_SIZE = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              wr,
    output logic [WIDTH1-1:0] addr,
    output logic [WIDTH1-1:0] wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    function automatic logic [7:0] f_chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_count;
    logic [15:0]       w_count_nxt;
    logic [31:0]       r_word;
    logic [31:0]       w_word_nxt;
    logic [1:0]        r_bidx;
    logic [1:0]        w_bidx_nxt;
    logic [7:0]        r_chk;
    logic [7:0]        w_chk_nxt;
    logic [15:0]       r_words;
    logic [15:0]       w_words_nxt;
    logic              r_wr;
    logic              w_wr_nxt;
    logic [WIDTH1-1:0] r_addr;
    logic [WIDTH1-1:0] w_addr_nxt;
    logic [WIDTH1-1:0] r_wdata;
    logic [WIDTH1-1:0] w_wdata_nxt;
    logic              r_done;
    logic              r_error;
    logic              r_hold;

    logic              w_accept;
    logic [15:0]       w_hdr_n;
    logic              w_hdr_bad;
    logic [31:0]       w_word_full;
    logic [15:0]       w_words_inc;

    assign in_ready = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                      (r_state == S_DATA) || (r_state == S_CHK);
    assign w_accept    = in_valid && in_ready;
    assign w_hdr_n     = {in_data, r_count[7:0]};
    assign w_hdr_bad   = (w_hdr_n == 16'd0) || ({16'd0, w_hdr_n} > 32'(MEM_SIZE));
    assign w_word_full = {in_data, r_word[31:8]};
    assign w_words_inc = r_words + 16'd1;

    // Next-state and next-register decode for the load sequence
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_word_nxt  = r_word;
        w_bidx_nxt  = r_bidx;
        w_chk_nxt   = r_chk;
        w_words_nxt = r_words;
        w_wr_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        case (r_state)
            S_HDR0: begin
                if (w_accept) begin
                    w_count_nxt = {8'h00, in_data};
                    w_state_nxt = S_HDR1;
                end else begin
                    w_state_nxt = S_HDR0;
                end
            end
            S_HDR1: begin
                if (w_accept) begin
                    w_count_nxt = w_hdr_n;
                    w_bidx_nxt  = 2'd0;
                    if (w_hdr_bad) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_HDR1;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_word_nxt = w_word_full;
                    w_chk_nxt  = f_chk_update(r_chk, in_data);
                    w_bidx_nxt = r_bidx + 2'd1;
                    // Fourth byte completes the word: launch the write on this edge
                    if (r_bidx == 2'd3) begin
                        w_state_nxt = S_WRITE;
                        w_wr_nxt    = 1'b1;
                        w_addr_nxt  = WIDTH1'(r_words);
                        w_wdata_nxt = WIDTH1'(w_word_full);
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_WRITE: begin
                w_words_nxt = w_words_inc;
                if (w_words_inc == r_count) begin
                    w_state_nxt = S_CHK;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    if (in_data == r_chk) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end else begin
                    w_state_nxt = S_CHK;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_HDR0;
                    w_words_nxt = 16'd0;
                    w_chk_nxt   = 8'h00;
                    w_bidx_nxt  = 2'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = S_HDR0;
            end
        endcase
    end

    // State and output registers; status flags are decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_HDR0;
            r_count <= 16'd0;
            r_word  <= 32'd0;
            r_bidx  <= 2'd0;
            r_chk   <= 8'h00;
            r_words <= 16'd0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_hold  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_word  <= w_word_nxt;
            r_bidx  <= w_bidx_nxt;
            r_chk   <= w_chk_nxt;
            r_words <= w_words_nxt;
            r_wr    <= w_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_error <= (w_state_nxt == S_ERR);
            r_hold  <= (w_state_nxt != S_DONE);
        end
    end

    assign wr           = r_wr;
    assign addr         = r_addr;
    assign wdata        = r_wdata;
    assign done         = r_done;
    assign error        = r_error;
    assign core_hold    = r_hold;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: good/bad images, header limits, back-pressure,
// asynchronous reset mid-frame and start re-arming.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam logic [31:0] W0 = 32'h00100093;
    localparam logic [31:0] W1 = 32'h00200113;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        start = 1'b0;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  frame_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    imem_loader #(.WIDTH1(32), .MEM_SIZE(1024)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
        .core_hold(core_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    // Write monitor: records every memory write strobe
    always @(negedge clk) begin
        if (reset && wr) begin
            wa_q.push_back(addr);
            wd_q.push_back(wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: byte %h never accepted, in_ready=%b exp 1", b, in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame_q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(frame_q[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({wr, addr, wdata, done, error, core_hold, words_loaded, in_ready} !==
            {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: wr=%b addr=%h wdata=%h done=%b err=%b hold=%b wl=%0d rdy=%b exp 0 0 0 0 0 1 0 1",
                     wr, addr, wdata, done, error, core_hold, words_loaded, in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_image();
        wa_q.delete(); wd_q.delete();
        frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_frame(1'b0);
        n_vec++;
        if ({wr, addr, wdata, in_ready} !== {1'b1, 32'd0, W0, 1'b0}) begin
            n_err++;
            $display("FAIL good_latency: wr=%b addr=%h wdata=%h rdy=%b exp 1 0 %h 0", wr, addr, wdata, in_ready, W0);
        end
        frame_q = '{8'h13, 8'h01, 8'h20, 8'h00, 8'hB1};
        send_frame(1'b0);
        n_vec++;
        if (wa_q.size() != 2) begin
            n_err++;
            $display("FAIL good_wr_count: got %0d exp 2", wa_q.size());
        end else begin
            n_vec++;
            if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {32'd0, W0, 32'd1, W1}) begin
                n_err++;
                $display("FAIL good_writes: got %h/%h %h/%h exp 0/%h 1/%h", wa_q[0], wd_q[0], wa_q[1], wd_q[1], W0, W1);
            end
        end
        n_vec++;
        if ({done, error, core_hold, words_loaded, addr, wdata} !== {1'b1, 1'b0, 1'b0, 16'd2, 32'd1, W1}) begin
            n_err++;
            $display("FAIL good_status: done=%b err=%b hold=%b wl=%0d addr=%h wdata=%h exp 1 0 0 2 1 %h",
                     done, error, core_hold, words_loaded, addr, wdata, W1);
        end
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        n_vec++;
        if ({done, error, core_hold, words_loaded} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL rearm_status: done=%b err=%b hold=%b wl=%0d exp 0 0 1 0", done, error, core_hold, words_loaded);
        end
        wa_q.delete(); wd_q.delete();
        frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hB0};
        send_frame(1'b0);
        n_vec++;
        if (wa_q.size() != 2 || wd_q[0] !== W0 || wd_q[1] !== W1) begin
            n_err++;
            $display("FAIL badchk_writes: count=%0d exp 2 with %h %h", wa_q.size(), W0, W1);
        end
        n_vec++;
        if ({done, error, core_hold} !== {1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL badchk_status: done=%b err=%b hold=%b exp 0 1 1", done, error, core_hold);
        end
    endtask

    task automatic test_bad_header();
        pulse_start();
        wa_q.delete(); wd_q.delete();
        frame_q = '{8'h00, 8'h00};
        send_frame(1'b0);
        n_vec++;
        if ({error, done, core_hold, in_ready} !== {1'b1, 1'b0, 1'b1, 1'b0} || wa_q.size() != 0) begin
            n_err++;
            $display("FAIL hdr_zero: err=%b done=%b hold=%b rdy=%b writes=%0d exp 1 0 1 0 0",
                     error, done, core_hold, in_ready, wa_q.size());
        end
        pulse_start();
        frame_q = '{8'h01, 8'h04};
        send_frame(1'b0);
        n_vec++;
        if ({error, done, in_ready} !== {1'b1, 1'b0, 1'b0} || wa_q.size() != 0) begin
            n_err++;
            $display("FAIL hdr_1025: err=%b done=%b rdy=%b writes=%0d exp 1 0 0 0", error, done, in_ready, wa_q.size());
        end
        pulse_start();
        frame_q = '{8'h00, 8'h04};
        send_frame(1'b0);
        n_vec++;
        if ({error, in_ready} !== {1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL hdr_1024: err=%b rdy=%b exp 0 1", error, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        wa_q.delete(); wd_q.delete();
        frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hB1};
        send_frame(1'b1);
        n_vec++;
        if (wa_q.size() != 2) begin
            n_err++;
            $display("FAIL bp_wr_count: got %0d exp 2", wa_q.size());
        end else begin
            n_vec++;
            if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {32'd0, W0, 32'd1, W1}) begin
                n_err++;
                $display("FAIL bp_writes: got %h/%h %h/%h exp 0/%h 1/%h", wa_q[0], wd_q[0], wa_q[1], wd_q[1], W0, W1);
            end
        end
        n_vec++;
        if ({done, error, core_hold, words_loaded} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
            n_err++;
            $display("FAIL bp_status: done=%b err=%b hold=%b wl=%0d exp 1 0 0 2", done, error, core_hold, words_loaded);
        end
    endtask

    task automatic test_reset_mid_frame();
        pulse_start();
        frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10};
        send_frame(1'b0);
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({wr, addr, wdata, done, error, core_hold, words_loaded, in_ready} !==
            {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: wr=%b addr=%h wdata=%h done=%b err=%b hold=%b wl=%0d rdy=%b exp 0 0 0 0 0 1 0 1",
                     wr, addr, wdata, done, error, core_hold, words_loaded, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wa_q.delete(); wd_q.delete();
        frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hB1};
        send_frame(1'b0);
        n_vec++;
        if (wa_q.size() != 2 || wa_q[1] !== 32'd1 || wd_q[0] !== W0 || wd_q[1] !== W1) begin
            n_err++;
            $display("FAIL resend_writes: count=%0d exp 2 with 0/%h 1/%h", wa_q.size(), W0, W1);
        end
        n_vec++;
        if ({done, error, core_hold, words_loaded} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
            n_err++;
            $display("FAIL resend_status: done=%b err=%b hold=%b wl=%0d exp 1 0 0 2", done, error, core_hold, words_loaded);
        end
    endtask

    task automatic test_start_rearm();
        pulse_start();
        n_vec++;
        if ({done, core_hold, words_loaded} !== {1'b0, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL start_clear: done=%b hold=%b wl=%0d exp 0 1 0", done, core_hold, words_loaded);
        end
        wa_q.delete(); wd_q.delete();
        frame_q = '{8'h01, 8'h00, 8'hEF};
        send_frame(1'b0);
        pulse_start();
        n_vec++;
        if ({in_ready, core_hold, done, error} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL start_in_data: rdy=%b hold=%b done=%b err=%b exp 1 1 0 0", in_ready, core_hold, done, error);
        end
        frame_q = '{8'hBE, 8'hAD, 8'hDE};
        send_frame(1'b0);
        n_vec++;
        if ({wr, addr, wdata, core_hold} !== {1'b1, 32'd0, 32'hDEADBEEF, 1'b1}) begin
            n_err++;
            $display("FAIL rearm_write: wr=%b addr=%h wdata=%h hold=%b exp 1 0 deadbeef 1", wr, addr, wdata, core_hold);
        end
        frame_q = '{8'h22};
        send_frame(1'b0);
        n_vec++;
        if ({done, error, core_hold, words_loaded} !== {1'b1, 1'b0, 1'b0, 16'd1} || wa_q.size() != 1) begin
            n_err++;
            $display("FAIL rearm_status: done=%b err=%b hold=%b wl=%0d writes=%0d exp 1 0 0 1 1",
                     done, error, core_hold, words_loaded, wa_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_image();
        test_bad_checksum();
        test_bad_header();
        test_back_pressure();
        test_reset_mid_frame();
        test_start_rearm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
